// File: rtl/video_timing_ctrl.sv
// Video timing generator: programmable h/v geometry with shadowed config,
// frame-aligned config commit, and registered sync/DE/coordinate outputs.
module video_timing_ctrl #(
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        enable,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_pending,
  output logic        cfg_applied,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        sof,
  output logic        running
);

  localparam int unsigned FW = 12;  // stored field width
  localparam int unsigned CW = 14;  // counter / total width
  localparam int unsigned NF = 8;   // number of timing fields

  // Field order (index 0 first): HA HFP HS HBP VA VFP VS VBP
  localparam logic [NF-1:0][FW-1:0] FIELD_RST = {
    12'd20, 12'd5, 12'd5, 12'd720, 12'd220, 12'd40, 12'd110, 12'd1280
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [NF-1:0][FW-1:0]  shadow;
  logic [NF-1:0][FW-1:0]  active;
  logic [NF-1:0][FW-1:0]  shadow_nxt;
  logic [CW-1:0]          hcnt;
  logic [CW-1:0]          vcnt;

  logic [CW-1:0] ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  logic [CW-1:0] htotal, vtotal, hs_start, hs_end, vs_start, vs_end;
  logic          last_h, last_v, last_pix, advance, xfer;
  logic          de_c, hs_c, vs_c, sof_c;

  // A stored zero behaves as a one-cycle/one-line field
  function automatic logic [CW-1:0] eff(input logic [FW-1:0] v);
    return (v == '0) ? CW'(1) : CW'(v);
  endfunction

  assign ha  = eff(active[0]);
  assign hfp = eff(active[1]);
  assign hsw = eff(active[2]);
  assign hbp = eff(active[3]);
  assign va  = eff(active[4]);
  assign vfp = eff(active[5]);
  assign vsw = eff(active[6]);
  assign vbp = eff(active[7]);

  // Frame geometry; 4 x 4095 fits in 14 bits so no overflow
  assign htotal   = ha + hfp + hsw + hbp;
  assign vtotal   = va + vfp + vsw + vbp;
  assign hs_start = ha + hfp;
  assign hs_end   = hs_start + hsw;
  assign vs_start = va + vfp;
  assign vs_end   = vs_start + vsw;

  assign last_h   = (hcnt >= htotal - CW'(1));
  assign last_v   = (vcnt >= vtotal - CW'(1));
  assign last_pix = last_h && last_v;
  assign advance  = (state != IDLE) || enable;
  assign xfer     = cfg_pending && ((state == IDLE) || last_pix);

  // Pixel decode of the current counter state, registered below
  assign de_c  = (hcnt < ha) && (vcnt < va);
  assign hs_c  = (hcnt >= hs_start) && (hcnt < hs_end);
  assign vs_c  = (vcnt >= vs_start) && (vcnt < vs_end);
  assign sof_c = (hcnt == '0) && (vcnt == '0);

  // Shadow image including this cycle's write, so a write on the transfer cycle is kept
  always_comb begin
    shadow_nxt = shadow;
    if (cfg_wr) shadow_nxt[cfg_addr] = cfg_data;
  end

  // Shadow/active config registers and commit handshake
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shadow      <= FIELD_RST;
      active      <= FIELD_RST;
      cfg_pending <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      cfg_applied <= xfer;
      cfg_pending <= cfg_commit || (cfg_pending && !xfer);
      if (xfer) active <= shadow_nxt;
    end
  end

  // Run-state FSM, raster counters and registered timing outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      running <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
      de      <= 1'b0;
      sof     <= 1'b0;
      x       <= '0;
      y       <= '0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (last_pix) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      if (advance) begin
        de    <= de_c;
        sof   <= sof_c;
        x     <= de_c ? hcnt[FW-1:0] : '0;
        y     <= de_c ? vcnt[FW-1:0] : '0;
        hsync <= hs_c ? HS_POL : ~HS_POL;
        vsync <= vs_c ? VS_POL : ~VS_POL;
        if (last_h) begin
          hcnt <= '0;
          vcnt <= last_v ? '0 : vcnt + CW'(1);
        end else begin
          hcnt <= hcnt + CW'(1);
        end
      end else begin
        de    <= 1'b0;
        sof   <= 1'b0;
        x     <= '0;
        y     <= '0;
        hsync <= ~HS_POL;
        vsync <= ~VS_POL;
        hcnt  <= '0;
        vcnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl: small geometries checked pixel by
// pixel against hand-derived raster rules, plus one default-timing line.
module tb_video_timing_ctrl;

  localparam logic HS_P = 1'b1;
  localparam logic VS_P = 1'b1;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        enable;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_pending;
  logic        cfg_applied;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] x;
  logic [11:0] y;
  logic        sof;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] IDLE_WORD = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ~HS_P, ~VS_P, 12'd0, 12'd0};

  video_timing_ctrl #(.HS_POL(HS_P), .VS_POL(VS_P)) dut (
    .CLK(CLK), .RSTn(RSTn), .enable(enable),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .cfg_applied(cfg_applied),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y), .sof(sof), .running(running)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {1'b0, running, cfg_applied, cfg_pending, sof, de, hsync, vsync, x, y};
  endfunction

  function automatic logic [31:0] hs_word();
    return {30'd0, cfg_pending, cfg_applied};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d, input logic commit);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d; cfg_commit = commit;
    tick();
    cfg_wr = 1'b0; cfg_commit = 1'b0;
  endtask

  // One whole frame compared per pixel; optional mid-frame HA commit and enable drop/raise
  task automatic frame_check(input int ha, input int hfp, input int hsw, input int hbp,
                             input int va, input int vfp, input int vsw, input int vbp,
                             input int commit_at, input int commit_val,
                             input int drop_at, input int raise_at);
    int ht, vt, last, h, v;
    logic de_e, hs_e, vs_e, pend_e, app_e, run_e;
    logic [31:0] exp_w;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    last = ht * vt - 1;
    for (int k = 0; k <= last; k++) begin
      tick();
      h = k % ht;
      v = k / ht;
      de_e   = (h < ha) && (v < va);
      hs_e   = (h >= ha + hfp) && (h < ha + hfp + hsw);
      vs_e   = (v >= va + vfp) && (v < va + vfp + vsw);
      pend_e = (commit_at >= 0) && (k > commit_at) && (k < last);
      app_e  = (commit_at >= 0) && (k == last);
      run_e  = !((drop_at >= 0) && (raise_at < 0) && (k == last));
      exp_w  = {1'b0, run_e, app_e, pend_e, (k == 0), de_e,
                hs_e ? HS_P : ~HS_P, vs_e ? VS_P : ~VS_P,
                de_e ? 12'(h) : 12'd0, de_e ? 12'(v) : 12'd0};
      chk($sformatf("pix ht=%0d k=%0d", ht, k), obs(), exp_w);
      if (k == commit_at) begin
        cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = 12'(commit_val); cfg_commit = 1'b1;
      end else begin
        cfg_wr = 1'b0; cfg_commit = 1'b0;
      end
      if (k == drop_at)  enable = 1'b0;
      if (k == raise_at) enable = 1'b1;
    end
  endtask

  initial begin
    int de_cnt, hs_first, hs_len;
    logic [11:0] x_last;
    logic [11:0] small_val [8];
    small_val = '{12'd4, 12'd1, 12'd2, 12'd1, 12'd3, 12'd1, 12'd1, 12'd1};

    RSTn = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    tick();
    chk("reset_state", obs(), IDLE_WORD);
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    chk("idle_after_reset", obs(), IDLE_WORD);

    // Small geometry written in IDLE, commit on the last write
    for (int i = 0; i < 8; i++) cfg_write(3'(i), small_val[i], (i == 7));
    chk("idle_commit_pending", hs_word(), 32'd2);
    tick();
    chk("idle_commit_applied", hs_word(), 32'd1);
    chk("idle_outputs", obs() & ~32'h2000_0000, IDLE_WORD);

    // Frame 1: enable dropped on line 1 and re-raised on line 3, no stop
    enable = 1'b1;
    frame_check(4, 1, 2, 1, 3, 1, 1, 1, -1, 0, 8, 24);
    // Frame 2: HA=6 committed mid-frame, current frame unaltered
    frame_check(4, 1, 2, 1, 3, 1, 1, 1, 10, 6, -1, -1);
    // Frame 3: new 10-cycle lines; enable dropped on line 1, frame drains to IDLE
    frame_check(6, 1, 2, 1, 3, 1, 1, 1, -1, 0, 10, -1);
    tick();
    chk("idle_after_drain", obs(), IDLE_WORD);
    tick();
    chk("idle_stays", obs(), IDLE_WORD);

    // Zero HS field behaves as one cycle
    cfg_write(3'd2, 12'd0, 1'b1);
    chk("hs0_pending", hs_word(), 32'd2);
    tick();
    chk("hs0_applied", hs_word(), 32'd1);
    enable = 1'b1;
    frame_check(6, 1, 1, 1, 3, 1, 1, 1, -1, 0, -1, -1);

    // Asynchronous reset mid-line
    tick(); tick(); tick();
    #2;
    RSTn = 1'b0;
    #1;
    chk("async_reset", obs(), IDLE_WORD);
    enable = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    chk("idle_after_async", obs(), IDLE_WORD);

    // Commit without writes: shadow must also be back at defaults
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    chk("dflt_applied", hs_word(), 32'd1);

    // One default line: 1650 pixels
    enable = 1'b1;
    de_cnt = 0; hs_first = -1; hs_len = 0; x_last = '0;
    for (int k = 0; k < 1650; k++) begin
      tick();
      if (k == 0) chk("dflt_first_pixel", obs(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ~HS_P, ~VS_P, 12'd0, 12'd0});
      if (de) de_cnt++;
      if (hsync == HS_P) begin
        if (hs_first < 0) hs_first = k;
        hs_len++;
      end
      if (k == 1279) x_last = x;
    end
    chk("dflt_de_count", 32'(de_cnt), 32'd1280);
    chk("dflt_hs_start", 32'(hs_first), 32'd1390);
    chk("dflt_hs_len", 32'(hs_len), 32'd40);
    chk("dflt_x_last", 32'(x_last), 32'd1279);
    tick();
    chk("dflt_line1_start", obs(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ~HS_P, ~VS_P, 12'd0, 12'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
